// File: rtl/serial_tick_sched_pkg.sv
// rtl/serial_tick_sched_pkg.sv - shared types and constants for the serial tick scheduler
package serial_tick_sched_pkg;

    // Per-channel frame state; busy is simply state == RUN.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    localparam int TELETYPE_FRAME_BITS = 11;
    localparam int DEFAULT_OVERSAMPLE  = 8;

    // Field widths sized to the parameter maxima (16 ticks/bit, 16 bits/frame, 8 channels).
    localparam int BIT_IDX_W = 4;
    localparam int PHASE_W   = 4;
    localparam int PTR_W     = 3;

endpackage

// File: rtl/serial_tick_sched_if.sv
// rtl/serial_tick_sched_if.sv - baud tick input, frame requests and per-channel frame outputs
// Signals:
//   tick_in  level baud clock (8x bit rate square wave)
//   req      per-channel frame-start request level
//   ack      one-cycle grant pulse
//   busy     frame in progress
//   bit_stb  one-cycle pulse per bit boundary (start bit included)
//   bit_idx  current bit number, channel n at [4n+3:4n]
//   done     one-cycle end-of-frame pulse
interface serial_tick_sched_if #(
    parameter int CHANNELS = 4
);
    logic                                              tick_in;
    logic [CHANNELS-1:0]                               req;
    logic [CHANNELS-1:0]                               ack;
    logic [CHANNELS-1:0]                               busy;
    logic [CHANNELS-1:0]                               bit_stb;
    logic [serial_tick_sched_pkg::BIT_IDX_W*CHANNELS-1:0] bit_idx;
    logic [CHANNELS-1:0]                               done;

    modport master (
        output tick_in, req,
        input  ack, busy, bit_stb, bit_idx, done
    );

    modport slave (
        input  tick_in, req,
        output ack, busy, bit_stb, bit_idx, done
    );
endinterface

// File: rtl/serial_tick_chan.sv
// rtl/serial_tick_chan.sv - per-channel phase/bit counters and frame state
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   tick        single-cycle baud tick
//   grant       frame start granted on this tick (only asserted while idle)
//   busy        frame in progress
//   bit_stb     bit-boundary pulse, bit_idx current bit, done end-of-frame pulse
module serial_tick_chan
    import serial_tick_sched_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int FRAME_BITS = TELETYPE_FRAME_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 grant,
    output logic                 busy,
    output logic                 bit_stb,
    output logic [BIT_IDX_W-1:0] bit_idx,
    output logic                 done
);
    localparam logic [PHASE_W-1:0]   PHASE_LAST = PHASE_W'(OVERSAMPLE - 1);
    localparam logic [BIT_IDX_W-1:0] BIT_LAST   = BIT_IDX_W'(FRAME_BITS - 1);

    sched_state_t         state_q;
    logic [PHASE_W-1:0]   phase_q;
    logic [BIT_IDX_W-1:0] bit_idx_q;
    logic                 bit_stb_q;
    logic                 done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_idx_q <= '0;
            bit_stb_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            bit_stb_q <= 1'b0;
            done_q    <= 1'b0;
            if (tick) begin
                if (grant) begin
                    state_q   <= RUN;
                    phase_q   <= '0;
                    bit_idx_q <= '0;
                    bit_stb_q <= 1'b1;
                end else if (state_q == RUN) begin
                    if (phase_q != PHASE_LAST) begin
                        phase_q <= phase_q + 1'b1;
                    end else begin
                        phase_q <= '0;
                        if (bit_idx_q != BIT_LAST) begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            bit_stb_q <= 1'b1;
                        end else begin
                            // bit_idx is left at the last bit until the next grant
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign busy    = (state_q == RUN);
    assign bit_stb = bit_stb_q;
    assign bit_idx = bit_idx_q;
    assign done    = done_q;

endmodule

// File: rtl/serial_tick_sched.sv
// rtl/serial_tick_sched.sv - shares one baud clock among serial channels with round-robin frame grants
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    slave side of serial_tick_sched_if (tick_in, req in; ack, busy, bit_stb, bit_idx, done out)
module serial_tick_sched
    import serial_tick_sched_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int FRAME_BITS = TELETYPE_FRAME_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_tick_sched_if.slave    bus
);
    logic                           prev_q;
    logic                           tick;
    logic [PTR_W-1:0]               rr_ptr_q;
    logic [PTR_W-1:0]               rr_ptr_d;
    logic [CHANNELS-1:0]            grant;
    logic [CHANNELS-1:0]            ack_q;
    logic [CHANNELS-1:0]            busy_w;
    logic [CHANNELS-1:0]            bit_stb_w;
    logic [CHANNELS-1:0]            done_w;
    logic [BIT_IDX_W*CHANNELS-1:0]  bit_idx_w;
    logic                           found;

    // prev resets high so a tick_in already high at reset release is not an edge.
    assign tick = bus.tick_in & ~prev_q;

    // Round-robin: scan rr_ptr..CHANNELS-1 first, then 0..rr_ptr-1.
    always_comb begin
        grant    = '0;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (!found && j >= int'(rr_ptr_q) && bus.req[j] && !busy_w[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                rr_ptr_d = (j == CHANNELS - 1) ? '0 : PTR_W'(j + 1);
            end
        end
        for (int j = 0; j < CHANNELS; j++) begin
            if (!found && j < int'(rr_ptr_q) && bus.req[j] && !busy_w[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                rr_ptr_d = PTR_W'(j + 1);
            end
        end
        if (!tick) begin
            grant    = '0;
            rr_ptr_d = rr_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q   <= 1'b1;
            rr_ptr_q <= '0;
            ack_q    <= '0;
        end else begin
            prev_q   <= bus.tick_in;
            rr_ptr_q <= rr_ptr_d;
            ack_q    <= grant;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        serial_tick_chan #(
            .OVERSAMPLE (OVERSAMPLE),
            .FRAME_BITS (FRAME_BITS)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick),
            .grant   (grant[g]),
            .busy    (busy_w[g]),
            .bit_stb (bit_stb_w[g]),
            .bit_idx (bit_idx_w[BIT_IDX_W*g +: BIT_IDX_W]),
            .done    (done_w[g])
        );
    end

    assign bus.ack     = ack_q;
    assign bus.busy    = busy_w;
    assign bus.bit_stb = bit_stb_w;
    assign bus.bit_idx = bit_idx_w;
    assign bus.done    = done_w;

endmodule

// File: tb/tb_serial_tick_sched.sv
// tb/tb_serial_tick_sched.sv - scoreboard bench for serial_tick_sched
module tb_serial_tick_sched;
    localparam int C  = 4;
    localparam int OS = 8;
    localparam int FB = 11;

    typedef struct packed {
        logic [C-1:0]   ack;
        logic [C-1:0]   busy;
        logic [C-1:0]   stb;
        logic [4*C-1:0] idx;
        logic [C-1:0]   done;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    serial_tick_sched_if #(.CHANNELS(C)) bus();

    serial_tick_sched #(
        .CHANNELS   (C),
        .OVERSAMPLE (OS),
        .FRAME_BITS (FB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   tick_half = 32;
    int   tick_cnt = 0;
    exp_t sbq[$];
    bit   started = 1'b0;

    // Reference model: each channel tracks ticks elapsed since its grant (-1 = idle).
    int age   [C];
    int m_idx [C];
    int m_ptr;
    bit m_prev;
    int cyc = 0;

    initial begin
        bus.tick_in = 1'b1;
        bus.req     = '0;
        forever begin
            @(negedge clk);
            tick_cnt++;
            if (tick_cnt >= tick_half) begin
                tick_cnt    = 0;
                bus.tick_in = ~bus.tick_in;
            end
        end
    end

    always @(posedge clk) begin
        exp_t e;
        bit   tk;
        int   win;
        e  = '0;
        cyc++;
        if (reset) begin
            for (int i = 0; i < C; i++) begin
                age[i]   = -1;
                m_idx[i] = 0;
            end
            m_ptr  = 0;
            m_prev = 1'b1;
        end else begin
            tk     = bus.tick_in && !m_prev;
            m_prev = bus.tick_in;
            if (tk) begin
                win = -1;
                for (int k = 0; k < C; k++) begin
                    int ch;
                    ch = (m_ptr + k) % C;
                    if (win < 0 && bus.req[ch] && age[ch] < 0) win = ch;
                end
                for (int i = 0; i < C; i++) begin
                    if (i == win) begin
                        age[i]   = 0;
                        m_idx[i] = 0;
                        e.ack[i] = 1'b1;
                        e.stb[i] = 1'b1;
                    end else if (age[i] >= 0) begin
                        age[i]++;
                        if (age[i] == FB * OS) begin
                            e.done[i] = 1'b1;
                            age[i]    = -1;
                        end else if (age[i] % OS == 0) begin
                            m_idx[i] = age[i] / OS;
                            e.stb[i] = 1'b1;
                        end
                    end
                end
                if (win >= 0) m_ptr = (win + 1) % C;
            end
        end
        for (int i = 0; i < C; i++) begin
            e.busy[i]        = (age[i] >= 0);
            e.idx[4*i +: 4]  = 4'(m_idx[i]);
        end
        sbq.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            started = 1'b1;
            e = sbq.pop_front();
            checks += 5;
            if (bus.ack !== e.ack) begin
                errors++;
                $display("FAIL ack cyc=%0d got=%b exp=%b", cyc, bus.ack, e.ack);
            end
            if (bus.busy !== e.busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.busy, e.busy);
            end
            if (bus.bit_stb !== e.stb) begin
                errors++;
                $display("FAIL bit_stb cyc=%0d got=%b exp=%b", cyc, bus.bit_stb, e.stb);
            end
            if (bus.bit_idx !== e.idx) begin
                errors++;
                $display("FAIL bit_idx cyc=%0d got=%h exp=%h", cyc, bus.bit_idx, e.idx);
            end
            if (bus.done !== e.done) begin
                errors++;
                $display("FAIL done cyc=%0d got=%b exp=%b", cyc, bus.done, e.done);
            end
        end else if (started) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty cyc=%0d got=0 exp=1", cyc);
        end
    end

    initial begin
        // Tick detection and single/re-requested frame on channel 0, slow ticks.
        reset     = 1'b1;
        tick_half = 32;
        repeat (5) @(negedge clk);
        reset   = 1'b0;
        bus.req = 4'b0001;
        repeat (6200) @(negedge clk);
        bus.req = 4'b0000;

        // Contention from reset with all channels requesting.
        reset     = 1'b1;
        tick_half = 2;
        bus.req   = 4'b1111;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (400) @(negedge clk);
        bus.req = 4'b0000;

        // Reset in the middle of a channel 3 frame, then a 0/3 contest.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        bus.req = 4'b1000;
        for (int k = 0; k < 100 && !bus.busy[3]; k++) @(negedge clk);
        checks++;
        if (!bus.busy[3]) begin
            errors++;
            $display("FAIL ch3_start got=%b exp=1", bus.busy[3]);
        end
        bus.req = 4'b0000;
        repeat (160) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        bus.req = 4'b1001;
        repeat (200) @(negedge clk);

        // Randomized traffic with varying tick rate and occasional resets.
        repeat (300) begin
            tick_half = $urandom_range(1, 4);
            bus.req   = 4'($urandom_range(0, 15));
            reset     = ($urandom_range(0, 40) == 0);
            repeat ($urandom_range(5, 100)) @(negedge clk);
        end
        reset   = 1'b0;
        bus.req = 4'b0000;
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
